// File: rtl/lms_pkg.sv
// lms_pkg -- shared types and helpers for the LMS adaptive filter engine.
//   state_t  : engine FSM encoding (also exported on the state_dbg port)
//   sat_val  : clamp a signed value to the range of a w-bit signed number
//   sat_clip : 1 when sat_val would have to clamp
package lms_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILTER = 3'd1,
    CALC   = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                 input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic logic sat_clip(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/lms_mac.sv
// lms_mac -- combinational multiply / add / saturate datapath shared by the
// FILTER (accumulate) and UPDATE (weight adjust) phases of lms_adapt_engine.
// Ports:
//   mul_a, mul_b : WIDTH-bit signed multiplicands
//   prod         : full 2*WIDTH-bit signed product
//   add_a, add_b : ACCW-bit signed addends (caller pre-aligns/extends them)
//   sum          : ACCW-bit signed sum (sized so it cannot overflow)
//   sum_sat      : sum clamped to WIDTH bits
//   sat_hit      : 1 when sum_sat differs from sum
module lms_mac
  import lms_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACCW  = 18
) (
  input  logic signed [WIDTH-1:0]   mul_a,
  input  logic signed [WIDTH-1:0]   mul_b,
  output logic signed [2*WIDTH-1:0] prod,
  input  logic signed [ACCW-1:0]    add_a,
  input  logic signed [ACCW-1:0]    add_b,
  output logic signed [ACCW-1:0]    sum,
  output logic signed [WIDTH-1:0]   sum_sat,
  output logic                      sat_hit
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [63:0]        sum_ext;

  // Operands are widened first so the product is computed at full width.
  assign a_ext   = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
  assign b_ext   = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
  assign prod    = a_ext * b_ext;

  assign sum     = add_a + add_b;
  assign sum_ext = {{(64-ACCW){sum[ACCW-1]}}, sum};
  assign sum_sat = WIDTH'(sat_val(sum_ext, WIDTH));
  assign sat_hit = sat_clip(sum_ext, WIDTH);

endmodule

// File: rtl/lms_adapt_engine.sv
// lms_adapt_engine -- sequential LMS adaptive FIR engine, one tap per cycle.
// An accepted sample pair (x, d) is shifted into the history, filtered
// (y = sum w[k]*x[k]), the error e = d - y is formed, and when adapt_en was
// set at accept the weights move by (e*x[k]) * 2^-MU_SHIFT. All arithmetic
// is Q1.(WIDTH-1) with floor rounding and saturation.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : sample pair handshake (x_in, d_in, adapt_en)
//   w_load_en/idx/data    : weight preload, honoured only while idle
//   out_valid/out_ready   : result handshake (y_out, e_out)
//   weights               : current weight array
//   sat_flag              : sticky, any saturation since reset
//   state_dbg             : current FSM state (lms_pkg::state_t encoding)
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both 1. A source holding valid keeps its data stable until that edge;
// y_out/e_out stay stable while out_valid is 1 and out_ready is 0.
module lms_adapt_engine
  import lms_pkg::*;
#(
  parameter int TAPS     = 4,
  parameter int WIDTH    = 8,
  parameter int MU_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    x_in,
  input  logic signed [WIDTH-1:0]    d_in,
  input  logic                       adapt_en,
  input  logic                       w_load_en,
  input  logic [$clog2(TAPS)-1:0]    w_load_idx,
  input  logic signed [WIDTH-1:0]    w_load_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    y_out,
  output logic signed [WIDTH-1:0]    e_out,
  output logic signed [WIDTH-1:0]    weights [0:TAPS-1],
  output logic                       sat_flag,
  output logic [2:0]                 state_dbg
);

  localparam int IW   = $clog2(TAPS);
  localparam int KW   = $clog2(TAPS + 1);
  localparam int PW   = 2 * WIDTH;
  localparam int ACCW = 2 * WIDTH + $clog2(TAPS);
  localparam int SH_Y = WIDTH - 1;
  localparam int SH_W = WIDTH - 1 + MU_SHIFT;

  state_t                  state;
  logic [KW-1:0]           k;
  logic [IW-1:0]           tap;
  logic signed [WIDTH-1:0] x_hist [0:TAPS-1];
  logic signed [WIDTH-1:0] d_q;
  logic                    adapt_q;
  logic signed [ACCW-1:0]  acc;
  logic signed [PW-1:0]    prod_q;

  logic signed [WIDTH-1:0] mul_a;
  logic signed [WIDTH-1:0] mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    prod_sh;
  logic signed [ACCW-1:0]  add_a;
  logic signed [ACCW-1:0]  add_b;
  logic signed [ACCW-1:0]  sum;
  logic signed [WIDTH-1:0] sum_sat;
  logic                    sat_hit;

  logic signed [ACCW-1:0]  acc_sh;
  logic signed [63:0]      acc_ext;
  logic signed [WIDTH-1:0] y_calc;
  logic                    y_clip;
  logic signed [WIDTH:0]   diff;
  logic signed [63:0]      diff_ext;
  logic signed [WIDTH-1:0] e_calc;
  logic                    e_clip;

  assign state_dbg = state;

  // FILTER runs k = 0..TAPS (one extra cycle to drain the product register),
  // so k can briefly equal TAPS; clamp the tap index to stay in range.
  always_comb begin
    tap = '0;
    if (k < KW'(TAPS)) tap = k[IW-1:0];
  end

  // Shared MAC operand select. FILTER: products are registered in prod_q and
  // accumulated one cycle later. UPDATE: w[k] + ((e*x[k]) >>> SH_W).
  always_comb begin
    mul_a   = weights[tap];
    mul_b   = x_hist[tap];
    add_a   = acc;
    add_b   = {{(ACCW-PW){prod_q[PW-1]}}, prod_q};
    prod_sh = prod >>> SH_W;
    if (state == UPDATE) begin
      mul_a = e_out;
      add_a = {{(ACCW-WIDTH){weights[tap][WIDTH-1]}}, weights[tap]};
      add_b = {{(ACCW-PW){prod_sh[PW-1]}}, prod_sh};
    end
  end

  lms_mac #(
    .WIDTH (WIDTH),
    .ACCW  (ACCW)
  ) u_mac (
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .prod    (prod),
    .add_a   (add_a),
    .add_b   (add_b),
    .sum     (sum),
    .sum_sat (sum_sat),
    .sat_hit (sat_hit)
  );

  // Output stage: y from the accumulator, e from the already-clamped y.
  always_comb begin
    acc_sh   = acc >>> SH_Y;
    acc_ext  = {{(64-ACCW){acc_sh[ACCW-1]}}, acc_sh};
    y_calc   = WIDTH'(sat_val(acc_ext, WIDTH));
    y_clip   = sat_clip(acc_ext, WIDTH);
    diff     = {d_q[WIDTH-1], d_q} - {y_calc[WIDTH-1], y_calc};
    diff_ext = {{(64-WIDTH-1){diff[WIDTH]}}, diff};
    e_calc   = WIDTH'(sat_val(diff_ext, WIDTH));
    e_clip   = sat_clip(diff_ext, WIDTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      e_out     <= '0;
      sat_flag  <= 1'b0;
      acc       <= '0;
      prod_q    <= '0;
      d_q       <= '0;
      adapt_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        weights[i] <= '0;
        x_hist[i]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          // The load lands before FILTER reads any weight, so a sample
          // accepted in the same cycle already sees the loaded value.
          if (w_load_en && (int'(w_load_idx) < TAPS))
            weights[w_load_idx] <= w_load_data;
          if (in_valid && in_ready) begin
            x_hist[0] <= x_in;
            for (int i = 1; i < TAPS; i++) x_hist[i] <= x_hist[i-1];
            d_q      <= d_in;
            adapt_q  <= adapt_en;
            k        <= '0;
            acc      <= '0;
            prod_q   <= '0;
            in_ready <= 1'b0;
            state    <= FILTER;
          end
        end
        FILTER: begin
          acc <= sum;
          if (k < KW'(TAPS)) prod_q <= prod;
          if (k == KW'(TAPS)) state <= CALC;
          else k <= k + KW'(1);
        end
        CALC: begin
          y_out <= y_calc;
          e_out <= e_calc;
          if (y_clip || e_clip) sat_flag <= 1'b1;
          k <= '0;
          if (adapt_q) begin
            state <= UPDATE;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        UPDATE: begin
          weights[tap] <= sum_sat;
          if (sat_hit) sat_flag <= 1'b1;
          if (k == KW'(TAPS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_adapt_engine.sv
// tb_lms_adapt_engine -- directed + randomized bench for lms_adapt_engine
// (TAPS=4, WIDTH=8, MU_SHIFT=2). An integer reference model predicts y, e,
// latency and weights at every accept; the predictions queue up and are
// compared when the engine presents its result.
module tb_lms_adapt_engine;
  import lms_pkg::*;

  localparam int TAPS = 4;
  localparam int W    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] d_in;
  logic               adapt_en;
  logic               w_load_en;
  logic [1:0]         w_load_idx;
  logic signed [W-1:0] w_load_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] e_out;
  logic signed [W-1:0] weights [0:TAPS-1];
  logic               sat_flag;
  logic [2:0]         state_dbg;

  lms_adapt_engine #(.TAPS(4), .WIDTH(8), .MU_SHIFT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_in        (x_in),
    .d_in        (d_in),
    .adapt_en    (adapt_en),
    .w_load_en   (w_load_en),
    .w_load_idx  (w_load_idx),
    .w_load_data (w_load_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y_out       (y_out),
    .e_out       (e_out),
    .weights     (weights),
    .sat_flag    (sat_flag),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic signed [W-1:0] exp_y_q[$];
  logic signed [W-1:0] exp_e_q[$];
  int                  exp_lat_q[$];

  int m_w [0:TAPS-1];
  int m_x [0:TAPS-1];
  bit m_sat;
  logic signed [W-1:0] last_y;
  logic signed [W-1:0] last_e;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_w[i] = 0;
      m_x[i] = 0;
    end
    m_sat = 1'b0;
    exp_y_q.delete();
    exp_e_q.delete();
    exp_lat_q.delete();
  endtask

  // Predicts one accepted sample: optional same-cycle load, history shift,
  // filter, error, optional weight update.
  task automatic model_accept(input bit ld, input int ld_idx, input int ld_data,
                              input int x, input int d, input bit adapt);
    int acc;
    int y;
    int e;
    int t;
    if (ld) m_w[ld_idx] = ld_data;
    for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = x;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += m_w[i] * m_x[i];
    t = acc >>> 7;
    y = sat8(t);
    if (y != t) m_sat = 1'b1;
    t = d - y;
    e = sat8(t);
    if (e != t) m_sat = 1'b1;
    if (adapt) begin
      for (int i = 0; i < TAPS; i++) begin
        t = m_w[i] + ((e * m_x[i]) >>> 9);
        m_w[i] = sat8(t);
        if (m_w[i] != t) m_sat = 1'b1;
      end
    end
    exp_y_q.push_back(W'(y));
    exp_e_q.push_back(W'(e));
    exp_lat_q.push_back(adapt ? 2 * TAPS + 2 : TAPS + 2);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_weights(input string tag);
    for (int i = 0; i < TAPS; i++)
      check($sformatf("%s_w%0d", tag, i), weights[i], m_w[i]);
  endtask

  task automatic load_w(input int idx, input int data);
    w_load_en   = 1'b1;
    w_load_idx  = 2'(idx);
    w_load_data = W'(data);
    tick();
    w_load_en   = 1'b0;
    m_w[idx]    = data;
  endtask

  // One full transaction: accept, wait for the result, compare against the
  // head of the expected queues; completes the handshake if out_ready is 1.
  task automatic send(input int x, input int d, input bit adapt, input bit ld,
                      input int ld_idx, input int ld_data, input string tag);
    int n;
    int el;
    logic signed [W-1:0] ey;
    logic signed [W-1:0] ee;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    x_in        = W'(x);
    d_in        = W'(d);
    adapt_en    = adapt;
    in_valid    = 1'b1;
    w_load_en   = ld;
    w_load_idx  = 2'(ld_idx);
    w_load_data = W'(ld_data);
    model_accept(ld, ld_idx, ld_data, x, d, adapt);
    tick();
    in_valid  = 1'b0;
    w_load_en = 1'b0;
    x_in      = W'($urandom_range(0, 255));
    d_in      = W'($urandom_range(0, 255));
    adapt_en  = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    el = exp_lat_q.pop_front();
    ey = exp_y_q.pop_front();
    ee = exp_e_q.pop_front();
    check({tag, "_lat"}, n, el);
    check({tag, "_y"}, y_out, ey);
    check({tag, "_e"}, e_out, ee);
    check_weights(tag);
    last_y = ey;
    last_e = ee;
    if (out_ready) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    d_in = '0;
    adapt_en = 1'b0;
    w_load_en = 1'b0;
    w_load_idx = '0;
    w_load_data = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y_out, 0);
    check("rst_e", e_out, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_state", state_dbg, 32'(IDLE));
    check_weights("rst");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Zero weights, adapt: y=0, e=32, w0 -> 4
    send(64, 32, 1'b1, 1'b0, 0, 0, "adapt0");
    check("adapt0_w0_lit", weights[0], 4);

    // Loaded w={32,0,0,0}, no adapt: y=16
    load_w(0, 32);
    send(64, 16, 1'b0, 1'b0, 0, 0, "noadapt");
    check("noadapt_y_lit", y_out, 16);

    // Load and accept in the same cycle: sample must use the new w1
    send(32, 0, 1'b0, 1'b1, 1, 64, "ldacc");

    // Saturation: w0=127, x=127, d=-128
    load_w(1, 0);
    load_w(0, 127);
    send(127, -128, 1'b1, 1'b0, 0, 0, "sat");
    check("sat_y_lit", last_y, 126);
    check("sat_flag_set", sat_flag, 1);

    // Result held in DONE while out_ready is low; in_valid is ignored
    out_ready = 1'b0;
    send(-40, 25, 1'b0, 1'b0, 0, 0, "hold");
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      x_in = W'($urandom_range(0, 255));
      tick();
      check($sformatf("hold%0d_ov", c), out_valid, 1);
      check($sformatf("hold%0d_ir", c), in_ready, 0);
      check($sformatf("hold%0d_y", c), y_out, last_y);
      check($sformatf("hold%0d_e", c), e_out, last_e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold_release_ov", out_valid, 0);
    check("hold_release_ir", in_ready, 1);

    // Randomized samples
    for (int r = 0; r < 6; r++) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           1'($urandom_range(0, 1)), 1'b0, 0, 0, $sformatf("rnd%0d", r));
    end
    check("sat_flag_sticky", sat_flag, 1);

    // Reset pulse in the middle of UPDATE
    x_in = W'(50);
    d_in = W'(-20);
    adapt_en = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("midupd_state", state_dbg, 32'(UPDATE));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_ov", out_valid, 0);
    check("midrst_ir", in_ready, 1);
    check("midrst_sat", sat_flag, 0);
    check("midrst_y", y_out, 0);
    check("midrst_state", state_dbg, 32'(IDLE));
    check_weights("midrst");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // First accept after reset behaves as from power-up
    send(64, 32, 1'b1, 1'b0, 0, 0, "postrst");
    check("postrst_w0_lit", weights[0], 4);

    // Back-to-back samples: history must become {30,20,10,0}
    model_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_w(0, 64);
    load_w(1, 32);
    load_w(2, 16);
    load_w(3, 8);
    fork
      begin : bb_drv
        int n;
        for (int s = 0; s < 3; s++) begin
          n = 0;
          while (!in_ready && n < 40) begin tick(); n++; end
          x_in = W'(10 * (s + 1));
          d_in = '0;
          adapt_en = 1'b0;
          in_valid = 1'b1;
          model_accept(1'b0, 0, 0, 10 * (s + 1), 0, 1'b0);
          tick();
        end
        in_valid = 1'b0;
      end
      begin : bb_mon
        int n;
        logic signed [W-1:0] ey;
        logic signed [W-1:0] ee;
        for (int s = 0; s < 3; s++) begin
          n = 0;
          while (!out_valid && n < 40) begin tick(); n++; end
          check($sformatf("bb%0d_ov", s), out_valid, 1);
          check($sformatf("bb%0d_qsize", s), 32'(exp_y_q.size() > 0), 1);
          if (exp_y_q.size() > 0) begin
            ey = exp_y_q.pop_front();
            ee = exp_e_q.pop_front();
            void'(exp_lat_q.pop_front());
            check($sformatf("bb%0d_y", s), y_out, ey);
            check($sformatf("bb%0d_e", s), e_out, ee);
          end
          tick();
        end
      end
    join
    // x_hist {30,20,10,0} with w {64,32,16,8}: 1920+640+160 = 2720 >>> 7 = 21
    check("bb_last_y_lit", y_out, 21);
    check("bb_end_ir", in_ready, 1);
    check("bb_end_ov", out_valid, 0);
    check("bb_q_empty", 32'(exp_y_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lms_adapt_engine.md
LMS_ADAPT_ENGINE -- requirements
Module: lms_adapt_engine

Interface
REQ-001 Parameter TAPS, default 4, number of filter taps (>=2).
REQ-002 Parameter WIDTH, default 8, signed sample/weight width, Q1.(WIDTH-1) fixed point.
REQ-003 Parameter MU_SHIFT, default 2, step size mu = 2^-MU_SHIFT.
REQ-004 Ports: clk  in  1  single clock; rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  sample pair offered; in_ready  out  1  engine accepts sample.
REQ-006 x_in  in  WIDTH signed  input sample; d_in  in  WIDTH signed  desired sample.
REQ-007 adapt_en  in  1  weight update enable, sampled at accept.
REQ-008 w_load_en  in  1; w_load_idx  in  $clog2(TAPS); w_load_data  in  WIDTH signed: weight preload.
REQ-009 out_valid  out  1; out_ready  in  1: result handshake.
REQ-010 y_out  out  WIDTH signed  filter output; e_out  out  WIDTH signed  error d-y.
REQ-011 weights  out  [0:TAPS-1] x WIDTH signed  current weight array.
REQ-012 sat_flag  out  1  sticky: any saturation since reset.

Function
REQ-013 FSM states IDLE, FILTER, CALC, UPDATE, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept = in_valid&&in_ready: x_hist[0]<=x_in, x_hist[i]<=x_hist[i-1], d latched, adapt_en latched, IDLE->FILTER, tap index k<=0.
REQ-015 FILTER: one tap per cycle, acc += weights[k]*x_hist[k], k=0..TAPS-1, then ->CALC; acc width 2*WIDTH+$clog2(TAPS).
REQ-016 CALC (1 cycle): y = sat_WIDTH(acc >>> (WIDTH-1)); e = sat_WIDTH(d - y); register y_out, e_out; ->UPDATE if latched adapt_en else ->DONE.
REQ-017 UPDATE: one tap per cycle, weights[k] <= sat_WIDTH(weights[k] + ((e*x_hist[k]) >>> (WIDTH-1+MU_SHIFT))), k=0..TAPS-1, then ->DONE.
REQ-018 Shifts SHALL be arithmetic (floor rounding); sat_WIDTH clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 Any clamp in REQ-016/017 SHALL set sat_flag; only reset clears it.
REQ-020 DONE: out_valid=1; y_out/e_out held stable until out_valid&&out_ready, then ->IDLE.
REQ-021 Latency: out_valid rises 2*TAPS+2 cycles after accept edge with adapt; TAPS+2 without.
REQ-022 w_load_en in IDLE writes weights[w_load_idx]; ignored in other states; out-of-range idx ignored.
REQ-023 w_load_en and accept in same IDLE cycle: load applied first, accepted sample uses loaded weight.
REQ-024 Inputs x_in, d_in, adapt_en SHALL be don't-care outside accept cycle.

Reset
REQ-025 rst asserted (any state, incl. mid-FILTER/UPDATE) SHALL asynchronously force: state IDLE, in_ready 1, out_valid 0, y_out 0, e_out 0, weights all 0, x_hist all 0, acc 0, k 0, sat_flag 0.
REQ-026 First accept after rst deassert SHALL behave as from power-up.

Structure
REQ-027 Package lms_pkg SHALL hold the state enum type and a sat function parameterised by width.
REQ-028 One sub-module lms_mac: signed multiply, accumulate/add, saturate, shared by FILTER and UPDATE.
REQ-029 All outputs SHALL be registered.

Verification (TAPS=4, WIDTH=8, MU_SHIFT=2)
REQ-030 Reset: rst pulse mid-UPDATE -> out_valid 0, in_ready 1, weights {0,0,0,0}, sat_flag 0 immediately.
REQ-031 Zero weights, x=64, d=32, adapt 1 -> out_valid at cycle 10, y=0, e=32, weights[0]=4, others 0.
REQ-032 adapt_en=0, loaded w={32,0,0,0}, x=64 -> out_valid at cycle 6, y=16, weights unchanged.
REQ-033 Preload w0=127, x=127, d=-128 -> y=126, e=-128 (clamped), sat_flag 1 and stays 1.
REQ-034 out_ready low 5 cycles in DONE -> y/e/out_valid held, in_ready 0, in_valid ignored.
REQ-035 Back-to-back samples 10,20,30 with out_ready=1 -> x_hist {30,20,10,0}, three outputs in order, no sample lost.
